pack_cm: RTL and testbench
==========================

// Module: pack_cm
// PURPOSE
//  Encryption-side ciphertext compressor: cm[i] = ((v'[i] + H1 - (m[i] << (EP-1))) mod 2^EP) >> (EP-ET), i = 0..255.
//  Reads v' (10-bit coeffs, 4 per 64-bit word) and the 256-bit message; writes 16 words of packed 4-bit cm.
//  Feeds the decryption-side unpack stage: cm word w holds coeffs 16w..16w+15, nibble j in bits [4j+3:4j].
// PARAMETERS
//  H1       10'd4  rounding constant, 2^(EQ-EP-1) with EQ=13, EP=10
//  V_BASE   9'd0   first v' word address (read_base_sel=0); 64 words
//  M_BASE   9'd0   first message word address (read_base_sel=1); 4 words
//  CM_BASE  9'd0   first cm write address; 16 words
// PORTS
//  clk            in   1   clock; all state on rising edge
//  rst_n          in   1   asynchronous reset, active low
//  start          in   1   one-cycle request; accepted in IDLE or DONE only
//  read_base_sel  out  1   0: v' memory, 1: message memory
//  read_address   out  9   read address; data returns on read_data next cycle
//  read_data      in   64  read data, 1-cycle latency
//  write_address  out  9   cm write address
//  write_data     out  64  cm word, 16 nibbles, coeff 16w+j in [4j+3:4j]
//  write_en       out  1   write strobe, one cycle per cm word
//  busy           out  1   high from start acceptance until DONE
//  done           out  1   high while in DONE
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; v_cnt=0, cm_cnt=0; m_buf=0, v_buf=0, cm_buf=0;
//   read_base_sel=0, write_en=0, busy=0, done=0; write_address=CM_BASE. Mid-operation reset aborts at once;
//   no write_en may occur during or after the reset edge until the next start.
//  Addresses: v: V_BASE+v_cnt (v_cnt 0..63, 7-bit to hold 64); m: M_BASE+v_cnt[5:4]; cm: CM_BASE+cm_cnt (0..15).
//  FSM (Moore outputs):
//   IDLE    : start -> FETCH_M, clear counters.
//   FETCH_M : read_base_sel=1, present m address. -> LOAD_M
//   LOAD_M  : m_buf <= read_data; present v address. -> LOAD_V
//   LOAD_V  : v_buf <= read_data; v_cnt++. -> COMPUTE
//   COMPUTE : cm_buf <= {nib3,nib2,nib1,nib0, cm_buf[63:16]}; m_buf <= m_buf >> 4; present v address.
//             v_cnt[1:0]==0 -> STORE, else -> LOAD_V
//   STORE   : write_en=1, write_data=cm_buf, cm_cnt++ (address incremented after the write).
//             v_cnt==64 -> DONE; v_cnt[3:0]==0 -> FETCH_M; else -> LOAD_V
//   DONE    : done=1, busy=0; start -> FETCH_M with counters cleared; else hold.
//  start while busy: ignored. read_address held stable at v address in non-fetch states.
//  Arithmetic, lane k=0..3: c = v_buf[16k+9:16k]; t = c + H1 - {m_buf[k], 9'd0} truncated to 10 bits
//   (mod 1024 wrap, borrow discarded); nib_k = t[9:6]. v_buf[16k+15:16k+10] ignored.
//  Latency: start accepted -> done = 4*(2 + 16*2 + 4) = 152 cycles; exactly 16 write_en pulses.
//  Bit order: m_buf bit b of word k <-> coeff 64k+b; v word n lane k <-> coeff 4n+k.
// STRUCTURE
//  saber_pkg: SABER_N=256, SABER_EP=10, SABER_ET=4, SABER_EQ=13, H1, state enum/encoding.
//  Sub-module pack_cm_lane: combinational 1-coeff compressor (c, m_bit) -> nibble; 4 instances.
//  Top: FSM, counters, m_buf/v_buf/cm_buf shift registers.
// TESTING
//  1 v'=0, m=0 -> all 16 cm words 0x0000_0000_0000_0000; done 152 cycles after start.
//  2 v'=0, m=all ones -> t=516 -> every word 0x8888_8888_8888_8888 at CM_BASE..CM_BASE+15.
//  3 only coeff 0 = 60, m=0 -> word0 = 0x0000_0000_0000_0001, others 0; coeff 255 = 1023, m bit 255=1 -> word15 nibble15 = 8 (wrap).
//  4 upper lane bits [15:10] set to 0x3F in every lane, v'=0, m=0 -> output identical to scenario 1.
//  5 rst_n low at cycle 70 of a run -> write_en, busy drop immediately; rerun after start gives full correct output.
//  6 random v', m (200 seeds) vs software model; start pulsed while busy ignored; start in DONE reruns.

Source files
------------

// File: rtl/pack_cm_pkg.sv
// -----------------------------------------------------------------------------
// pack_cm_pkg
//   Shared constants and types for the ciphertext compressor (pack_cm).
//   Ring size and bit widths, the rounding constant, memory geometry and
//   the FSM state encoding.
// -----------------------------------------------------------------------------
package pack_cm_pkg;

    localparam int SABER_N  = 256;  // coefficients per polynomial
    localparam int SABER_EP = 10;   // v' coefficient width
    localparam int SABER_ET = 4;    // compressed cm width
    localparam int SABER_EQ = 13;

    // 2^(EQ-EP-1): half an LSB of the dropped bits, turns truncation into rounding
    localparam logic [SABER_EP-1:0] SABER_H1 = 10'd4;

    localparam int WORD_W   = 64;
    localparam int ADDR_W   = 9;
    localparam int LANES    = 4;                 // v' coeffs per 64-bit word
    localparam int LANE_W   = WORD_W / LANES;    // 16-bit lane slot
    localparam int COEFF_W  = SABER_EP;
    localparam int NIB_W    = SABER_ET;
    localparam int CNT_W    = 7;                 // must hold 64

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH_M = 3'd1,
        S_LOAD_M  = 3'd2,
        S_LOAD_V  = 3'd3,
        S_COMPUTE = 3'd4,
        S_STORE   = 3'd5,
        S_DONE    = 3'd6
    } state_t;

endpackage

// File: rtl/pack_cm_if.sv
// -----------------------------------------------------------------------------
// pack_cm_if
//   Memory/control bus of pack_cm.
//   start         : one-cycle run request
//   read_base_sel : 0 = v' memory, 1 = message memory
//   read_address  : read address, data returns on read_data one cycle later
//   read_data     : 64-bit read data
//   write_address : cm write address
//   write_data    : packed cm word (16 nibbles)
//   write_en      : one-cycle write strobe per cm word
//   busy / done   : run status
//   master = the compressor, slave = memories / controller.
// -----------------------------------------------------------------------------
interface pack_cm_if;
    import pack_cm_pkg::*;

    logic                start;
    logic                read_base_sel;
    logic [ADDR_W-1:0]   read_address;
    logic [WORD_W-1:0]   read_data;
    logic [ADDR_W-1:0]   write_address;
    logic [WORD_W-1:0]   write_data;
    logic                write_en;
    logic                busy;
    logic                done;

    modport master (
        input  start, read_data,
        output read_base_sel, read_address, write_address, write_data,
               write_en, busy, done
    );

    modport slave (
        output start, read_data,
        input  read_base_sel, read_address, write_address, write_data,
               write_en, busy, done
    );

endinterface

// File: rtl/pack_cm_lane.sv
// -----------------------------------------------------------------------------
// pack_cm_lane
//   Combinational single-coefficient compressor.
//   i_c     : 10-bit v' coefficient
//   i_m_bit : message bit for this coefficient
//   o_nib   : top 4 bits of (c + H1 - m*2^(EP-1)) mod 2^EP
// -----------------------------------------------------------------------------
module pack_cm_lane
    import pack_cm_pkg::*;
#(
    parameter logic [COEFF_W-1:0] H1 = SABER_H1
) (
    input  logic [COEFF_W-1:0] i_c,
    input  logic               i_m_bit,
    output logic [NIB_W-1:0]   o_nib
);

    logic [COEFF_W-1:0] w_t;

    // 10-bit arithmetic: the wrap mod 2^EP and the discarded borrow are intended
    assign w_t   = i_c + H1 - {i_m_bit, {(COEFF_W-1){1'b0}}};
    assign o_nib = w_t[COEFF_W-1 -: NIB_W];

endmodule

// File: rtl/pack_cm.sv
// -----------------------------------------------------------------------------
// pack_cm
//   Encryption-side ciphertext compressor. Reads 64 v' words (4 x 10-bit
//   coeffs in 16-bit lanes) and 4 message words, writes 16 packed cm words,
//   coeff 16w+j in nibble j of word w.
//   clk   : clock, rising edge
//   rst_n : asynchronous reset, active low
//   bus   : pack_cm_if.master (start, read port, write port, busy/done)
// Per message word: FETCH_M, LOAD_M, then 16 x (LOAD_V, COMPUTE) with a
// STORE after every 4th COMPUTE -> 38 cycles, 152 cycles per run.
// All bus outputs come from registers; addresses are loaded on entry to the
// state that presents them, so the 1-cycle memory returns data in the next
// state.
// -----------------------------------------------------------------------------
module pack_cm
    import pack_cm_pkg::*;
#(
    parameter logic [COEFF_W-1:0] H1      = SABER_H1,
    parameter logic [ADDR_W-1:0]  V_BASE  = 9'd0,
    parameter logic [ADDR_W-1:0]  M_BASE  = 9'd0,
    parameter logic [ADDR_W-1:0]  CM_BASE = 9'd0
) (
    input  logic      clk,
    input  logic      rst_n,
    pack_cm_if.master bus
);

    state_t                            r_state;
    logic [CNT_W-1:0]                  r_v_cnt;
    logic [4:0]                        r_cm_cnt;
    logic [WORD_W-1:0]                 r_m_buf;
    logic [LANES-1:0][COEFF_W-1:0]     r_v_buf;
    logic [WORD_W-1:0]                 r_cm_buf;
    logic                              r_base_sel;
    logic [ADDR_W-1:0]                 r_rd_addr;
    logic                              r_wr_en;
    logic                              r_busy;
    logic                              r_done;

    logic [CNT_W-1:0]                  w_v_cnt_inc;
    logic [ADDR_W-1:0]                 w_v_addr_cur;
    logic [ADDR_W-1:0]                 w_v_addr_inc;
    logic [ADDR_W-1:0]                 w_m_addr;
    logic [LANES-1:0][NIB_W-1:0]       w_nib;

    assign w_v_cnt_inc  = r_v_cnt + 7'd1;
    assign w_v_addr_cur = V_BASE + {2'b00, r_v_cnt};
    assign w_v_addr_inc = V_BASE + {2'b00, w_v_cnt_inc};
    // each message word covers 16 v' words
    assign w_m_addr     = M_BASE + {7'b0, r_v_cnt[5:4]};

    // lane k: coeff 4n+k, its message bit sits at m_buf[k] (m_buf shifts by 4 per word)
    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            pack_cm_lane #(.H1(H1)) u_lane (
                .i_c     (r_v_buf[k]),
                .i_m_bit (r_m_buf[k]),
                .o_nib   (w_nib[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_v_cnt    <= '0;
            r_cm_cnt   <= '0;
            r_m_buf    <= '0;
            r_v_buf    <= '0;
            r_cm_buf   <= '0;
            r_base_sel <= 1'b0;
            r_rd_addr  <= V_BASE;
            r_wr_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;   // only raised on the way into STORE
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state    <= S_FETCH_M;
                        r_v_cnt    <= '0;
                        r_cm_cnt   <= '0;
                        r_base_sel <= 1'b1;
                        r_rd_addr  <= M_BASE;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                    end
                end
                S_FETCH_M: begin
                    r_state    <= S_LOAD_M;
                    r_base_sel <= 1'b0;
                    r_rd_addr  <= w_v_addr_cur;
                end
                S_LOAD_M: begin
                    r_m_buf <= bus.read_data;
                    r_state <= S_LOAD_V;
                end
                S_LOAD_V: begin
                    // lane bits [15:10] are padding and are dropped here
                    for (int i = 0; i < LANES; i++)
                        r_v_buf[i] <= bus.read_data[LANE_W*i +: COEFF_W];
                    r_v_cnt   <= w_v_cnt_inc;
                    r_rd_addr <= w_v_addr_inc;
                    r_state   <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    // after 4 words the first word's nibbles have reached [15:0]
                    r_cm_buf <= {w_nib, r_cm_buf[WORD_W-1:LANES*NIB_W]};
                    r_m_buf  <= r_m_buf >> LANES;
                    if (r_v_cnt[1:0] == 2'd0) begin
                        r_state <= S_STORE;
                        r_wr_en <= 1'b1;
                    end else begin
                        r_state <= S_LOAD_V;
                    end
                end
                S_STORE: begin
                    r_cm_cnt <= r_cm_cnt + 5'd1;
                    if (r_v_cnt == 7'd64) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_v_cnt[3:0] == 4'd0) begin
                        r_state    <= S_FETCH_M;
                        r_base_sel <= 1'b1;
                        r_rd_addr  <= w_m_addr;
                    end else begin
                        r_state <= S_LOAD_V;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.read_base_sel = r_base_sel;
    assign bus.read_address  = r_rd_addr;
    assign bus.write_address = CM_BASE + {4'b0, r_cm_cnt};
    assign bus.write_data    = r_cm_buf;
    assign bus.write_en      = r_wr_en;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;

endmodule

// File: tb/tb_pack_cm.sv
// -----------------------------------------------------------------------------
// tb_pack_cm
//   Bench for pack_cm: memory model on the read port, write capture on the
//   write port, table of uniform-fill vectors with hand-computed words,
//   directed corner sequences and randomized runs against an arithmetic
//   model of the compression formula.
// -----------------------------------------------------------------------------
module tb_pack_cm;
    import pack_cm_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pack_cm_if bus();

    pack_cm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [63:0] v_mem [64];
    logic [63:0] m_mem [4];
    logic [63:0] got   [16];
    int          wr_count;
    int          n_checks = 0;
    int          n_fail   = 0;

    // 1-cycle latency memories, bases are 0
    always @(posedge clk)
        bus.read_data <= bus.read_base_sel ? m_mem[bus.read_address[1:0]]
                                           : v_mem[bus.read_address[5:0]];

    always @(negedge clk)
        if (bus.write_en) begin
            if (bus.write_address < 9'd16) got[bus.write_address[3:0]] = bus.write_data;
            wr_count++;
        end

    typedef struct {
        logic [63:0] v;     // every v' word
        logic [63:0] m;     // every message word
        logic [63:0] exp;   // every cm word
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // cm word w from the formula, coeff by coeff
    function automatic logic [63:0] model_word(input int w);
        logic [63:0] r;
        int c, mb, t;
        r = '0;
        for (int j = 0; j < 16; j++) begin
            c  = int'(v_mem[(16*w+j)/4][16*((16*w+j)%4) +: 10]);
            mb = int'(m_mem[(16*w+j)/64][(16*w+j)%64]);
            t  = (c + 4 + 1024 - 512*mb) % 1024;
            r[4*j +: 4] = 4'(t / 64);
        end
        return r;
    endfunction

    task automatic fill(input logic [63:0] v, input logic [63:0] m);
        for (int i = 0; i < 64; i++) v_mem[i] = v;
        for (int i = 0; i < 4; i++)  m_mem[i] = m;
    endtask

    // pulse start, optionally poke start again while busy, check latency and write count
    task automatic do_run(input string tag, input int poke);
        int cyc;
        wr_count = 0;
        for (int w = 0; w < 16; w++) got[w] = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        cyc = 0;
        while (!bus.done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            bus.start = (cyc == poke);
            if (cyc == 10) chk({tag, " busy"}, {62'd0, bus.busy, bus.done}, 64'd2);
        end
        bus.start = 1'b0;
        chk({tag, " latency"}, 64'(cyc), 64'd152);
        chk({tag, " writes"}, 64'(wr_count), 64'd16);
    endtask

    task automatic cmp_model(input string tag);
        for (int w = 0; w < 16; w++)
            chk($sformatf("%s w%0d", tag, w), got[w], model_word(w));
    endtask

    initial begin
        bus.start = 1'b0;
        fill('0, '0);

        tbl[0] = '{64'h0000_0000_0000_0000, 64'h0,  64'h0000_0000_0000_0000};
        tbl[1] = '{64'h0000_0000_0000_0000, '1,     64'h8888_8888_8888_8888};
        tbl[2] = '{64'hFC00_FC00_FC00_FC00, 64'h0,  64'h0000_0000_0000_0000};
        tbl[3] = '{64'h003C_003C_003C_003C, 64'h0,  64'h1111_1111_1111_1111};
        tbl[4] = '{64'h03FF_03FF_03FF_03FF, '1,     64'h8888_8888_8888_8888};
        tbl[5] = '{64'h03FF_03FF_03FF_03FF, 64'h0,  64'h0000_0000_0000_0000};
        tbl[6] = '{64'h03C0_03C0_03C0_03C0, 64'h0,  64'hFFFF_FFFF_FFFF_FFFF};
        tbl[7] = '{64'h03C0_03C0_03C0_03C0, '1,     64'h7777_7777_7777_7777};
        tbl[8] = '{64'h0000_0000_0000_0000, 64'hAAAA_AAAA_AAAA_AAAA, 64'h8080_8080_8080_8080};

        // reset state
        #1;
        chk("rst outs", {58'd0, bus.read_base_sel, bus.write_en, bus.busy, bus.done, 2'b00}, 64'd0);
        chk("rst waddr", 64'(bus.write_address), 64'd0);
        chk("rst wdata", bus.write_data, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle busy", {62'd0, bus.busy, bus.done}, 64'd0);

        // table vectors
        for (int t = 0; t < 9; t++) begin
            fill(tbl[t].v, tbl[t].m);
            do_run($sformatf("tbl%0d", t), 0);
            for (int w = 0; w < 16; w++)
                chk($sformatf("tbl%0d w%0d", t, w), got[w], tbl[t].exp);
        end

        // coeff 0 = 60 -> word0 nibble0 = 1; coeff 255 = 1023 with m bit 255 -> wraps to 8
        fill('0, '0);
        v_mem[0]  = 64'h0000_0000_0000_003C;
        v_mem[63] = 64'h03FF_0000_0000_0000;
        m_mem[3]  = 64'h8000_0000_0000_0000;
        do_run("edge", 0);
        chk("edge w0", got[0], 64'h0000_0000_0000_0001);
        chk("edge w15", got[15], 64'h8000_0000_0000_0000);
        chk("edge w7", got[7], 64'h0);

        // reset in the middle of a run
        for (int i = 0; i < 64; i++) v_mem[i] = {$urandom, $urandom};
        for (int i = 0; i < 4; i++)  m_mem[i] = {$urandom, $urandom};
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        repeat (70) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort outs", {61'd0, bus.write_en, bus.busy, bus.done}, 64'd0);
        chk("abort waddr", 64'(bus.write_address), 64'd0);
        wr_count = 0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort quiet", {31'd0, bus.busy, 32'(wr_count)}, 64'd0);
        do_run("rerun", 0);
        cmp_model("rerun");

        // random runs; every run starts from DONE, some get a start while busy
        for (int s = 0; s < 200; s++) begin
            for (int i = 0; i < 64; i++) v_mem[i] = {$urandom, $urandom};
            for (int i = 0; i < 4; i++)  m_mem[i] = {$urandom, $urandom};
            do_run($sformatf("rnd%0d", s), (s % 3 == 0) ? int'($urandom_range(2, 140)) : 0);
            cmp_model($sformatf("rnd%0d", s));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
